// File: rtl/riscv_pkg.sv
// Shared core definitions: data widths, the bubble encoding, the fetch FSM
// states and the IF/ID payload.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CNTW = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory port and
// the IF/ID outputs. The slave side is the fetch stage itself.
interface instruction_fetch_stage_if;
  import riscv_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] Inst_Address;
  logic [ILEN-1:0] Instruction;
  logic [XLEN-1:0] if_id_pc;
  logic [ILEN-1:0] if_id_inst;
  logic            if_id_valid;
  logic            halted;
  logic            fetch_fault;
  logic [CNTW-1:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, Instruction,
    input  Inst_Address, if_id_pc, if_id_inst, if_id_valid,
           halted, fetch_fault, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, Instruction,
    output Inst_Address, if_id_pc, if_id_inst, if_id_valid,
           halted, fetch_fault, fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > flush (bubble) > hold > load.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [ILEN-1:0] BUBBLE_INST = NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold_i,
  input  logic            flush_i,
  input  fetch_pkt_t      load_i,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] inst_q;
  logic            valid_q;

  // A flushed slot keeps the PC it was squashed at, purely as a debug aid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= BUBBLE_INST;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      pc_q    <= load_i.pc;
      inst_q  <= BUBBLE_INST;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      pc_q    <= load_i.pc;
      inst_q  <= load_i.inst;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, the RUN/HALT fetch FSM, the sticky misalignment
// fault and the fetch counter; IF/ID storage lives in if_id_reg.
module instruction_fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 64'h0,
  parameter int unsigned                MEM_BYTES = 88,
  parameter logic [riscv_pkg::ILEN-1:0] NOP_INST  = riscv_pkg::NOP_INST
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_stage_if.slave   fif
);

  localparam int unsigned XLEN = riscv_pkg::XLEN;
  localparam int unsigned CNTW = riscv_pkg::CNTW;
  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  riscv_pkg::fetch_state_e state_q;
  logic [XLEN-1:0]         pc_q;
  logic                    fault_q;
  logic [CNTW-1:0]         count_q;

  logic                    in_range_c;
  logic                    misaligned_c;
  logic                    running_c;
  logic                    capture_c;
  logic                    hold_c;
  logic                    flush_c;
  riscv_pkg::fetch_pkt_t   pkt_c;

  assign in_range_c   = (pc_q < MEM_LIMIT);
  assign misaligned_c = |fif.branch_target[1:0];
  assign running_c    = (state_q == riscv_pkg::RUN);
  assign capture_c    = running_c && !fif.branch_taken && !fif.stall && in_range_c;
  assign hold_c       = !capture_c;
  // Redirects squash the wrong-path fetch; running off the image drops one bubble.
  assign flush_c      = fif.branch_taken || (running_c && !fif.stall && !in_range_c);
  assign pkt_c        = '{pc: pc_q, inst: fif.Instruction};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= riscv_pkg::RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
    end else if (fif.branch_taken) begin
      if (misaligned_c) begin
        fault_q <= 1'b1;
        state_q <= riscv_pkg::HALT;
      end else if (fault_q) begin
        state_q <= riscv_pkg::HALT;
      end else begin
        // Out-of-image aligned targets are accepted; RUN halts on the next cycle.
        pc_q    <= fif.branch_target;
        state_q <= riscv_pkg::RUN;
      end
    end else if (!fif.stall && running_c) begin
      if (in_range_c) begin
        pc_q <= pc_q + PC_STEP;
        if (count_q != '1) begin
          count_q <= count_q + CNTW'(1);
        end
      end else begin
        state_q <= riscv_pkg::HALT;
      end
    end
  end

  if_id_reg #(
    .BUBBLE_INST (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .hold_i  (hold_c),
    .flush_i (flush_c),
    .load_i  (pkt_c),
    .pc_o    (fif.if_id_pc),
    .inst_o  (fif.if_id_inst),
    .valid_o (fif.if_id_valid)
  );

  assign fif.Inst_Address = pc_q;
  assign fif.halted       = (state_q == riscv_pkg::HALT);
  assign fif.fetch_fault  = fault_q;
  assign fif.fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: table of per-cycle vectors fed through a
// scoreboard queue, then a few hand-written redirect/stall/halt sequences.
module tb_instruction_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  instruction_fetch_stage_if fif ();

  instruction_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  // Program image: three given words, then addi x0,x0,i at word i.
  function automatic logic [31:0] img(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    if (a >= 64'd88 || a[1:0] != 2'b00) return 32'hDEAD_BEEF;
    case (w)
      64'd0:   return 32'h0000_0913;
      64'd1:   return 32'h0000_0433;
      64'd2:   return 32'h04B4_0863;
      default: return 32'h0000_0013 | (32'(w) << 20);
    endcase
  endfunction

  always_comb fif.Instruction = img(fif.Inst_Address);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        halt;
    logic        fault;
    logic [31:0] cnt;
    logic        chk_pc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, input logic stall, input logic br,
                              input logic [63:0] tgt, input logic [63:0] addr,
                              input logic [63:0] pc, input logic [31:0] inst,
                              input logic valid, input logic halt, input logic fault,
                              input logic [31:0] cnt, input logic chk_pc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
    v.addr = addr; v.pc = pc; v.inst = inst; v.valid = valid;
    v.halt = halt; v.fault = fault; v.cnt = cnt; v.chk_pc = chk_pc;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic br, input logic [63:0] tgt);
    reset             = rst;
    fif.stall         = stall;
    fif.branch_taken  = br;
    fif.branch_target = tgt;
  endtask

  task automatic step(input logic rst, input logic stall, input logic br, input logic [63:0] tgt);
    drive(rst, stall, br, tgt);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t e;
    drive(1'b1, 1'b0, 1'b0, 64'h0);

    // rst stall br tgt | addr pc inst valid halt fault cnt chk_pc
    add(1,0,0,64'h0,  64'h0,  64'h0, NOP,          0,0,0,32'd0, 1);
    add(0,0,0,64'h0,  64'h4,  64'h0, 32'h00000913, 1,0,0,32'd1, 1);
    add(0,0,0,64'h0,  64'h8,  64'h4, 32'h00000433, 1,0,0,32'd2, 1);
    add(0,1,0,64'h0,  64'h8,  64'h4, 32'h00000433, 1,0,0,32'd2, 1);
    add(0,1,0,64'h0,  64'h8,  64'h4, 32'h00000433, 1,0,0,32'd2, 1);
    add(0,0,0,64'h0,  64'hC,  64'h8, 32'h04B40863, 1,0,0,32'd3, 1);
    add(0,1,1,64'h2C, 64'h2C, 64'h0, NOP,          0,0,0,32'd3, 0);
    add(0,0,0,64'h0,  64'h30, 64'h2C,32'h00B00013, 1,0,0,32'd4, 1);
    for (int k = 0; k < 10; k++) begin
      add(0,0,0,64'h0, 64'h34 + 64'(4*k), 64'h30 + 64'(4*k), img(64'h30 + 64'(4*k)),
          1,0,0, 32'(5+k), 1);
    end
    add(0,0,0,64'h0,  64'h58, 64'h58,NOP,          0,1,0,32'd14,1);
    add(0,0,0,64'h0,  64'h58, 64'h58,NOP,          0,1,0,32'd14,1);
    add(0,0,1,64'h0,  64'h0,  64'h0, NOP,          0,0,0,32'd14,0);
    add(0,0,0,64'h0,  64'h4,  64'h0, 32'h00000913, 1,0,0,32'd15,1);
    add(0,0,1,64'h2E, 64'h4,  64'h0, NOP,          0,1,1,32'd15,0);
    add(0,0,1,64'h0,  64'h4,  64'h0, NOP,          0,1,1,32'd15,0);
    add(0,0,0,64'h0,  64'h4,  64'h0, NOP,          0,1,1,32'd15,0);
    add(1,0,0,64'h0,  64'h0,  64'h0, NOP,          0,0,0,32'd0, 1);
    for (int k = 0; k < 5; k++) begin
      add(0,0,0,64'h0, 64'(4*(k+1)), 64'(4*k), img(64'(4*k)), 1,0,0, 32'(k+1), 1);
    end
    add(1,0,0,64'h0,  64'h0,  64'h0, NOP,          0,0,0,32'd0, 1);
    add(0,0,0,64'h0,  64'h4,  64'h0, 32'h00000913, 1,0,0,32'd1, 1);
    add(0,0,1,64'h60, 64'h60, 64'h0, NOP,          0,0,0,32'd1, 0);
    add(0,0,0,64'h0,  64'h60, 64'h60,NOP,          0,1,0,32'd1, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_addr", i),  fif.Inst_Address, e.addr);
        if (e.chk_pc) chk($sformatf("v%0d_pc", i), fif.if_id_pc, e.pc);
        chk($sformatf("v%0d_inst", i),  64'(fif.if_id_inst),  64'(e.inst));
        chk($sformatf("v%0d_valid", i), 64'(fif.if_id_valid), 64'(e.valid));
        chk($sformatf("v%0d_halt", i),  64'(fif.halted),      64'(e.halt));
        chk($sformatf("v%0d_fault", i), 64'(fif.fetch_fault), 64'(e.fault));
        chk($sformatf("v%0d_count", i), 64'(fif.fetch_count), 64'(e.cnt));
      end
    end

    // Redirect+stall must not reach Inst_Address before the edge.
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("seq_addr_run", fif.Inst_Address, 64'h4);
    drive(1'b0, 1'b1, 1'b1, 64'h40);
    #1;
    chk("seq_addr_no_comb", fif.Inst_Address, 64'h4);
    @(posedge clk);
    @(negedge clk);
    chk("seq_redir_addr",  fif.Inst_Address, 64'h40);
    chk("seq_redir_valid", 64'(fif.if_id_valid), 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    chk("seq_stall_addr",  fif.Inst_Address, 64'h40);
    chk("seq_stall_inst",  64'(fif.if_id_inst), 64'(NOP));
    chk("seq_stall_count", 64'(fif.fetch_count), 64'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("seq_cap_pc",    fif.if_id_pc, 64'h40);
    chk("seq_cap_inst",  64'(fif.if_id_inst), 64'h0100_0013);
    chk("seq_cap_count", 64'(fif.fetch_count), 64'd2);

    // Halt at end of image, stall while halted, then stalled redirect out.
    step(1'b0, 1'b0, 1'b1, 64'h58);
    chk("seq_edge_halt0", 64'(fif.halted), 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("seq_edge_halt1", 64'(fif.halted), 64'd1);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    chk("seq_halt_stall",      64'(fif.halted), 64'd1);
    chk("seq_halt_stall_addr", fif.Inst_Address, 64'h58);
    step(1'b0, 1'b1, 1'b1, 64'h8);
    chk("seq_exit_halt", 64'(fif.halted), 64'd0);
    chk("seq_exit_addr", fif.Inst_Address, 64'h8);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("seq_exit_inst",  64'(fif.if_id_inst), 64'h04B4_0863);
    chk("seq_exit_valid", 64'(fif.if_id_valid), 64'd1);
    chk("seq_exit_count", 64'(fif.fetch_count), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
